// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  localparam int SUB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = x - y - bi, bo set when x < y + bi.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & (y | bi)) | (y & bi);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial N-bit subtractor: one bit per cycle LSB first, results and flags
// registered on entry to DONE with a one-cycle done pulse.
module sub_serial
  import sub_pkg::*;
#(
  parameter int N = SUB_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         z,
  output logic         n,
  output logic         v,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic          borrow_reg;
  logic [N-1:0]  acc_reg;
  logic [N-1:0]  d_reg;
  logic          bout_reg;
  logic          z_reg;
  logic          n_reg;
  logic          v_reg;
  logic          busy_reg;
  logic          done_reg;

  logic          diff_bit;
  logic          borrow_next;
  logic [N-1:0]  acc_next;

  full_subtractor u_cell (
    .x    (a_reg[0]),
    .y    (b_reg[0]),
    .bi   (borrow_reg),
    .diff (diff_bit),
    .bo   (borrow_next)
  );

  // Difference bits enter at the MSB and drift down, so after N shifts the
  // accumulator holds the whole word in place.
  assign acc_next = {diff_bit, acc_reg[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      acc_reg    <= '0;
      d_reg      <= '0;
      bout_reg   <= 1'b0;
      z_reg      <= 1'b0;
      n_reg      <= 1'b0;
      v_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          borrow_reg <= borrow_next;
          acc_reg    <= acc_next;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            // borrow_reg is the borrow into the MSB stage on this cycle.
            d_reg     <= acc_next;
            bout_reg  <= borrow_next;
            z_reg     <= (acc_next == '0);
            n_reg     <= diff_bit;
            v_reg     <= borrow_reg ^ borrow_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign d    = d_reg;
  assign bout = bout_reg;
  assign z    = z_reg;
  assign n    = n_reg;
  assign v    = v_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial (N=4): directed vectors, expected results
// queued at issue time and checked by an independent done monitor.
module tb_sub_serial;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic [N-1:0] d;
  logic         bout;
  logic         z;
  logic         n;
  logic         v;
  logic         busy;
  logic         done;

  sub_serial #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .d    (d),
    .bout (bout),
    .z    (z),
    .n    (n),
    .v    (v),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] d;
    logic         bout;
    logic         v;
    int           start_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   last_done_cyc = -1;
  int   done_gap = 0;

  // Hand-computed vectors: a, b, bin -> d, bout, v (z and n follow from d).
  logic [N-1:0] va   [10] = '{4'b1000, 4'b0000, 4'b1001, 4'b0111, 4'b1111,
                              4'b0101, 4'b1000, 4'b0000, 4'b1010, 4'b0110};
  logic [N-1:0] vb   [10] = '{4'b1000, 4'b0001, 4'b1111, 4'b1000, 4'b1111,
                              4'b0011, 4'b0001, 4'b0000, 4'b0011, 4'b0010};
  logic         vbin [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [N-1:0] vd   [10] = '{4'b0000, 4'b1111, 4'b1010, 4'b1111, 4'b1111,
                              4'b0001, 4'b0111, 4'b1111, 4'b0111, 4'b0011};
  logic         vbo  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         vv   [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("d", d, mon_e.d);
        check("bout", bout, mon_e.bout);
        check("z", z, mon_e.d == '0);
        check("n", n, mon_e.d[N-1]);
        check("v", v, mon_e.v);
        check("latency", cyc - mon_e.start_cyc, N);
        $display("done: d=%b bout=%b z=%b n=%b v=%b at cycle %0d", d, bout, z, n, v, cyc);
      end
      if (last_done_cyc >= 0) done_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
    end
  end

  function automatic exp_t mk_exp(input int i, input int sc);
    exp_t e;
    e.d = vd[i];
    e.bout = vbo[i];
    e.v = vv[i];
    e.start_cyc = sc;
    return e;
  endfunction

  // Drive one start pulse; returns just after the accepting edge.
  task automatic issue(input int i, input bit push);
    @(posedge clk);
    #1;
    start = 1'b1;
    a = va[i];
    b = vb[i];
    bin = vbin[i];
    @(posedge clk);
    #1;
    if (push) sb_q.push_back(mk_exp(i, cyc));
    start = 1'b0;
    a = ~va[i];
    b = ~vb[i];
    bin = ~vbin[i];
    check("busy_after_start", busy, 1'b1);
    $display("issue: a=%b b=%b bin=%b at cycle %0d", va[i], vb[i], vbin[i], cyc);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic run_op(input int i);
    int cnt;
    issue(i, 1'b1);
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    // The negedge right after the accepting edge is counted by the loop.
    check("busy_cycles", cnt - 1, N);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_z", z, 0);
    check("rst_n", n, 0);
    check("rst_v", v, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_op(i);

    // A start pulsed mid-operation with other operands must be ignored.
    issue(5, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    a = va[0];
    b = vb[3];
    bin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Reset during the second SHIFT cycle aborts without a done pulse.
    issue(2, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    repeat (N + 3) @(posedge clk);

    run_op(6);

    // Back-to-back: start held high into DONE launches the next operation.
    @(posedge clk);
    #1;
    start = 1'b1;
    a = va[7];
    b = vb[7];
    bin = vbin[7];
    @(posedge clk);
    #1;
    sb_q.push_back(mk_exp(7, cyc));
    repeat (N) @(posedge clk);
    #1;
    check("b2b_done_first", done, 1);
    a = va[8];
    b = vb[8];
    bin = vbin[8];
    @(posedge clk);
    #1;
    sb_q.push_back(mk_exp(8, cyc));
    start = 1'b0;
    a = 4'b0101;
    b = 4'b1010;
    wait_idle();
    @(posedge clk);
    #1;
    check("b2b_done_gap", done_gap, N + 1);

    run_op(9);

    for (int k = 0; k < 50; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    check("queue_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
